// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_W         = $clog2(WIDTH_DEFAULT);

  // Bit counter width for an arbitrary operand width (never below 1).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational one-bit full subtractor cell: d = a - b - br, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ br;
  assign bo = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = x - y - bin, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;
  logic             last;

  full_subtractor u_fs (
    .a  (xs[0]),
    .b  (ys[0]),
    .br (br),
    .d  (d),
    .bo (bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Result bits enter xs from the MSB as minuend bits leave from the LSB,
  // so xs doubles as the diff shift register; on the last bit xs[0] is x's MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xs    <= '0;
      ys    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xs    <= x;
            ys    <= y;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          xs  <= {d, xs[WIDTH-1:1]};
          ys  <= ys >> 1;
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (last) begin
            diff  <= {d, xs[WIDTH-1:1]};
            bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (xs[0] != ys[0]) && (d != xs[0]);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=4), hand-computed expectations.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns just after that edge.
  task automatic kick(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    @(negedge clk);
    x = xv; y = yv; bin = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = '1; y = '1; bin = ~bv;
  endtask

  // Count edges until done; returns 0 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic bv, input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    kick(xv, yv, bv);
    check_eq({tag, ".busy"}, busy, 1);
    wait_done(n);
    check_eq({tag, ".lat"}, n, W + 1);
    check_eq({tag, ".busy_at_done"}, busy, 0);
    check_eq({tag, ".diff"}, diff, ed);
    check_eq({tag, ".bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check_eq({tag, ".ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    @(posedge clk);
    #1;
    check_eq({tag, ".done_1cyc"}, done, 0);
    check_eq({tag, ".diff_hold"}, diff, ed);
  endtask

  initial begin
    int pulses;
    #12;
    check_eq("rst.diff", diff, 0);
    check_eq("rst.bout", bout, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op("t3", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    run_op("t4", 4'b0101, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0);

    // Second start two cycles into the operation must be ignored.
    kick(4'b1000, 4'b1000, 1'b0);
    pulses = 0;
    if (done) pulses++;
    @(negedge clk);
    @(negedge clk);
    x = 4'b1111; y = 4'b0000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) pulses++;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_eq("t5.pulses", pulses, 1);
    check_eq("t5.diff", diff, 4'b0000);
    check_eq("t5.bout", bout, 0);

    run_op("t2", 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0);

    // Reset mid-SHIFT: immediate clear, no done afterwards.
    kick(4'b0011, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6.diff", diff, 0);
    check_eq("t6.bout", bout, 0);
    check_eq("t6.busy", busy, 0);
    check_eq("t6.done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check_eq("t6.no_done", pulses, 0);
    run_op("t6b", 4'b0101, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
